// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_cnt_w(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// DIGIT-bit ripple chain of full-adder cells; also exposes the carry into the slice MSB.
module fa_slice
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB slice first,
// with ready/valid handshakes on operand and result sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIGIT-1:0] slice_s;
    logic             slice_co, slice_cmsb;
    logic             last_step;

    fa_slice #(.DIGIT(DIGIT)) u_fa_slice (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .ci       (carry_q),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_cmsb)
    );

    assign last_step = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        overflow  = ovf_q;
    end

    // Subtraction is a + ~b + 1: B is inverted at load and the carry seeded with 1.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d = a_q >> DIGIT;
                b_d = b_q >> DIGIT;
                sum_d[int'(cnt_q) * DIGIT +: DIGIT] = slice_s;
                carry_d = slice_co;
                cnt_d   = cnt_q + 1'b1;
                if (last_step) begin
                    cout_d = slice_co;
                    ovf_d  = slice_cmsb ^ slice_co;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a DIGIT=1 and a DIGIT=4 instance share clock and reset.
module tb_serial_adder;

    localparam int WIDTH  = 8;
    localparam int STEPS1 = WIDTH / 1;
    localparam int STEPS4 = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic             in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
    logic [WIDTH-1:0] a, b, sum;
    logic             in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, overflow4;
    logic [WIDTH-1:0] a4, b4, sum4;

    res_t q1[$];
    res_t q4[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH), .DIGIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    serial_adder #(.WIDTH(WIDTH), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .cout(cout4), .overflow(overflow4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference: wide addition, sign-rule overflow.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] yy;
        res_t             e;
        yy    = s ? ~y : y;
        r     = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, (s ? 1'b1 : ci)};
        e.sum  = r[WIDTH-1:0];
        e.cout = r[WIDTH];
        e.ovf  = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xc, input logic xs, input int hold, input bit scramble);
        res_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        check_val("in_ready_pre", in_ready, 1);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        q1.push_back(model(xa, xb, xc, xs));
        @(posedge clk);
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 4 * STEPS1 + 8 && !seen; i++) begin
            @(negedge clk);
            if (scramble) begin
                in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) seen = 1;
        end
        in_valid = 1'b0;
        check_val("latency", lat, STEPS1);
        if (q1.size() == 0) begin
            check_val("sb_underflow", 0, 1);
            e = '0;
        end else begin
            e = q1.pop_front();
        end
        check_val("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_in_ready", in_ready, 0);
            check_val("hold_sum", sum, e.sum);
            check_val("hold_cout", cout, e.cout);
        end
        check_val("sum", sum, e.sum);
        check_val("cout", cout, e.cout);
        check_val("overflow", overflow, e.ovf);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("out_valid_post", out_valid, 0);
        check_val("in_ready_post", in_ready, 1);
        check_val("sum_idle", sum, e.sum);
    endtask

    task automatic run_op4(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                           input logic xc, input logic xs);
        res_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        a4 = xa; b4 = xb; cin4 = xc; sub4 = xs; in_valid4 = 1'b1;
        q4.push_back(model(xa, xb, xc, xs));
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 4 * STEPS4 + 8 && !seen; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid4) seen = 1;
        end
        check_val("latency4", lat, STEPS4);
        if (q4.size() == 0) begin
            check_val("sb4_underflow", 0, 1);
            e = '0;
        end else begin
            e = q4.pop_front();
        end
        check_val("sum4", sum4, e.sum);
        check_val("cout4", cout4, e.cout);
        check_val("overflow4", overflow4, e.ovf);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        check_val("in_ready4_post", in_ready4, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 0;
        in_valid4 = 0; a4 = '0; b4 = '0; cin4 = 0; sub4 = 0; out_ready4 = 0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_sum", sum, 0);
        check_val("rst_cout", cout, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_in_ready4", in_ready4, 1);
        rst_n = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 0);
        run_op(8'h05, 8'h07, 1'b1, 1'b1, 0, 0);
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 5, 1);
        for (int i = 0; i < 6; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 1);

        run_op4(8'h9C, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            run_op4(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        // Abort a running operation with an asynchronous reset between edges.
        @(negedge clk);
        a = 8'hA5; b = 8'h3C; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_in_ready", in_ready, 1);
        check_val("abort_sum", sum, 0);
        check_val("abort_cout", cout, 0);
        check_val("abort_sum4", sum4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 0);
        check_val("abort_result", sum, 8'h46);

        check_val("sb_drained", q1.size() + q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
